// File: rtl/memory_control_if.sv
// -----------------------------------------------------------------------------
// memory_control_if
//
// Bundles the CPU-side request/response signals of the IF and MEM pipeline
// stages together with the single mmu port that memory_control arbitrates.
//
// Signals:
//   if_req, if_address          IF fetch request (level) and byte address
//   if_data, wait_if            fetched word and IF stall
//   op_mem                      MEM op: 00 none, 01 write, 10 read, 11 none
//   mem_address, mem_byte_en    MEM byte address and write byte lanes
//   mem_data_in                 MEM write data
//   mem_data_out, wait_mem      MEM read word and MEM stall
//   mmu_write_enable            byte write enables to the mmu
//   mmu_address, mmu_data_in    address / write data to the mmu
//   mmu_data_out                read data from the mmu
//
// Modports:
//   slave   the arbiter (memory_control)
//   master  the CPU stages plus the mmu (the environment around the arbiter)
// -----------------------------------------------------------------------------
interface memory_control_if;
  logic        if_req;
  logic [31:0] if_address;
  logic [31:0] if_data;
  logic        wait_if;

  logic [1:0]  op_mem;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        wait_mem;

  logic [3:0]  mmu_write_enable;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;

  modport slave (
    input  if_req, if_address, op_mem, mem_address, mem_byte_en, mem_data_in,
           mmu_data_out,
    output if_data, wait_if, mem_data_out, wait_mem,
           mmu_write_enable, mmu_address, mmu_data_in
  );

  modport master (
    output if_req, if_address, op_mem, mem_address, mem_byte_en, mem_data_in,
           mmu_data_out,
    input  if_data, wait_if, mem_data_out, wait_mem,
           mmu_write_enable, mmu_address, mmu_data_in
  );
endinterface

// File: rtl/memory_control.sv
// -----------------------------------------------------------------------------
// memory_control
//
// Single-port arbiter between the CPU instruction-fetch (IF) and memory (MEM)
// stages and the mmu. One access at a time; address, write data and owner are
// latched on acceptance and held on the mmu port for the whole access. Reads
// wait a fixed READ_LATENCY; writes pulse mmu_write_enable for one cycle.
// MEM has priority over IF, but an accepted access always runs to completion.
// Every access ends in a one-cycle DONE state, during which the owner's stall
// drops, followed by at least one IDLE cycle before the next acceptance.
//
// Parameters:
//   READ_LATENCY  cycles from mmu_address valid to mmu_data_out valid (>= 1)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    memory_control_if.slave (IF/MEM stage signals and the mmu port)
//
// Optional feature (compile-time macro):
//   MEMORY_CONTROL_IF_BUFFER_EN  one-entry fetch buffer. A fetch hitting the
//                                buffered word tag completes from IDLE straight
//                                to DONE without an mmu access. Any MEM write
//                                invalidates the buffer.
// -----------------------------------------------------------------------------
module memory_control #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  memory_control_if.slave bus
);

  localparam int unsigned      CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_READ,
    S_MEM_READ,
    S_MEM_WRITE,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_e;

  state_e            state_q;
  owner_e            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_data_q;

  logic              mem_op_valid;
  logic              mem_op_write;
  logic              read_last;
  logic              buf_hit;
  logic [31:0]       buf_data;

  // 2'b11 is reserved and behaves exactly like "no operation".
  assign mem_op_write = (bus.op_mem == OP_WRITE);
  assign mem_op_valid = mem_op_write || (bus.op_mem == OP_READ);

  // Final cycle of a read: the mmu word is valid and gets captured this edge.
  assign read_last = (cnt_q == '0);

`ifdef MEMORY_CONTROL_IF_BUFFER_EN
  logic        buf_valid_q;
  logic [29:0] buf_tag_q;
  logic [31:0] buf_data_q;

  // Tag is the word address, so fetches differing only in byte offset share
  // the entry.
  assign buf_hit  = buf_valid_q && (buf_tag_q == bus.if_address[31:2]);
  assign buf_data = buf_data_q;

  // The buffer holds architecturally visible state (it can short-circuit a
  // fetch), so unlike a plain data RAM it must come out of reset invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == S_MEM_WRITE) begin
      // Conservative: any write may alias the buffered word.
      buf_valid_q <= 1'b0;
    end else if (state_q == S_IF_READ && read_last) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= addr_q[31:2];
      buf_data_q  <= bus.mmu_data_out;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Access sequencer. All mmu-facing outputs are registers, so the mmu port
  // is glitch-free and stays stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // branch below sees the pre-edge values regardless of statement order.
      // The default clear keeps the write strobe to exactly one cycle.
      we_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (mem_op_valid) begin
            owner_q <= OWN_MEM;
            addr_q  <= bus.mem_address;
            wdata_q <= bus.mem_data_in;
            if (mem_op_write) begin
              state_q <= S_MEM_WRITE;
              we_q    <= bus.mem_byte_en;
            end else begin
              state_q <= S_MEM_READ;
              cnt_q   <= CNT_LOAD;
            end
          end else if (bus.if_req) begin
            owner_q <= OWN_IF;
            if (buf_hit) begin
              // Served locally; the mmu port keeps its previous contents.
              if_data_q <= buf_data;
              state_q   <= S_DONE;
            end else begin
              addr_q  <= bus.if_address;
              wdata_q <= bus.mem_data_in;
              state_q <= S_IF_READ;
              cnt_q   <= CNT_LOAD;
            end
          end
        end

        S_IF_READ, S_MEM_READ: begin
          if (read_last) begin
            // The data register is updated even if the requester has since
            // dropped its request; only the stall release is then unseen.
            if (state_q == S_IF_READ) begin
              if_data_q <= bus.mmu_data_out;
            end else begin
              mem_data_q <= bus.mmu_data_out;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_MEM_WRITE: state_q <= S_DONE;

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stalls are combinational on the request so a stage is held from the very
  // cycle it asks; they drop only in the owner's DONE cycle. In reset the FSM
  // sits in IDLE, so each stall simply mirrors its request.
  assign bus.wait_if  = bus.if_req && !(state_q == S_DONE && owner_q == OWN_IF);
  assign bus.wait_mem = mem_op_valid && !(state_q == S_DONE && owner_q == OWN_MEM);

  assign bus.if_data          = if_data_q;
  assign bus.mem_data_out     = mem_data_q;
  assign bus.mmu_write_enable = we_q;
  assign bus.mmu_address      = addr_q;
  assign bus.mmu_data_in      = wdata_q;

endmodule

// File: tb/tb_memory_control.sv
// -----------------------------------------------------------------------------
// tb_memory_control
//
// Randomized bench for memory_control. A reference model tracks the memory
// image, the single-server timing of the arbiter (accept edge, completion
// cycle, next free acceptance) and, when MEMORY_CONTROL_IF_BUFFER_EN is
// defined, the fetch buffer. Expected completions are queued at issue time;
// a monitor on the falling edge pops and compares whenever a stage sees its
// stall drop or the mmu sees a write strobe.
// -----------------------------------------------------------------------------
module tb_memory_control;

  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic mmu_init;
  logic mon_en;
  int   cyc = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_control_if bus ();

  memory_control #(.READ_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- mmu model
  logic [31:0] mmu_mem [16];

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Read data is always presented for the current address, which is a legal
  // (early-valid) mmu; latency is checked through completion cycles instead.
  assign bus.mmu_data_out = mmu_mem[bus.mmu_address[5:2]];

  always @(posedge clk) begin
    if (mmu_init) begin
      for (int i = 0; i < 16; i++) mmu_mem[i] <= init_word(i);
    end else if (bus.mmu_write_enable != 4'b0000) begin
      mmu_mem[bus.mmu_address[5:2]] <= merge(mmu_mem[bus.mmu_address[5:2]],
                                             bus.mmu_data_in, bus.mmu_write_enable);
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        is_read;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  wr_t  wr_q[$];

  // ------------------------------------------------------- reference model
  logic [31:0] ref_mem [16];
  int          next_free = 0;   // earliest cycle value right after an accept edge
`ifdef MEMORY_CONTROL_IF_BUFFER_EN
  logic        bufm_valid = 1'b0;
  logic [29:0] bufm_tag   = '0;
`endif

  // c_req: cycle in which the request is first driven (arbiter in IDLE or busy).
  task automatic plan_if(input int c_req, input logic [31:0] addr);
    int   a;
    exp_t e;
    a = (c_req + 1 > next_free) ? c_req + 1 : next_free;
    e.data    = ref_mem[addr[5:2]];
    e.is_read = 1'b1;
    e.cyc     = a + LAT;
`ifdef MEMORY_CONTROL_IF_BUFFER_EN
    if (bufm_valid && bufm_tag == addr[31:2]) begin
      e.cyc = a;
    end else begin
      bufm_valid = 1'b1;
      bufm_tag   = addr[31:2];
    end
`endif
    next_free = e.cyc + 2;
    if_q.push_back(e);
  endtask

  task automatic plan_mem(input int c_req, input logic [1:0] op, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    int   a;
    exp_t e;
    wr_t  w;
    a = (c_req + 1 > next_free) ? c_req + 1 : next_free;
    if (op == 2'b01) begin
      w.addr = addr; w.be = be; w.data = data; w.cyc = a;
      wr_q.push_back(w);
      ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], data, be);
`ifdef MEMORY_CONTROL_IF_BUFFER_EN
      bufm_valid = 1'b0;
`endif
      e.is_read = 1'b0;
      e.data    = '0;
      e.cyc     = a + 1;
    end else begin
      e.is_read = 1'b1;
      e.data    = ref_mem[addr[5:2]];
      e.cyc     = a + LAT;
    end
    next_free = e.cyc + 2;
    mem_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t mon_e;
  wr_t  mon_w;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (bus.if_req && !bus.wait_if) begin
        if (if_q.size() == 0) fail_now("if_spurious_done");
        else begin
          mon_e = if_q.pop_front();
          check("if_done_cycle", cyc, mon_e.cyc);
          check("if_data", bus.if_data, mon_e.data);
        end
      end
      if ((bus.op_mem == 2'b01 || bus.op_mem == 2'b10) && !bus.wait_mem) begin
        if (mem_q.size() == 0) fail_now("mem_spurious_done");
        else begin
          mon_e = mem_q.pop_front();
          check("mem_done_cycle", cyc, mon_e.cyc);
          if (mon_e.is_read) check("mem_data_out", bus.mem_data_out, mon_e.data);
        end
      end
      if (bus.mmu_write_enable != 4'b0000) begin
        if (wr_q.size() == 0) fail_now("mmu_spurious_write");
        else begin
          mon_w = wr_q.pop_front();
          check("wr_cycle", cyc, mon_w.cyc);
          check("wr_addr", bus.mmu_address, mon_w.addr);
          check("wr_be", {28'd0, bus.mmu_write_enable}, {28'd0, mon_w.be});
          check("wr_data", bus.mmu_data_in, mon_w.data);
        end
      end
    end
  end

  // ------------------------------------------------------------- requesters
  // Each holds its request until it sees its stall low, then drops it on the
  // edge that ends that cycle, as a pipeline stage would.
  task automatic if_port(input logic [31:0] addr);
    int n;
    n = 0;
    bus.if_address = addr;
    bus.if_req     = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wait_if && n < 200);
    if (bus.wait_if) fail_now("if_timeout");
    @(posedge clk);
    #1 bus.if_req = 1'b0;
  endtask

  task automatic mem_port(input logic [1:0] op, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    int n;
    n = 0;
    bus.mem_address = addr;
    bus.mem_byte_en = be;
    bus.mem_data_in = data;
    bus.op_mem      = op;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wait_mem && n < 200);
    if (bus.wait_mem) fail_now("mem_timeout");
    @(posedge clk);
    #1 bus.op_mem = 2'b00;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, k, c0;
    logic [31:0] ia, ma, md;
    logic [1:0]  mop;
    logic [3:0]  be;

    reset           = 1'b1;
    mmu_init        = 1'b1;
    mon_en          = 1'b0;
    bus.if_req      = 1'b1;
    bus.if_address  = 32'h0;
    bus.op_mem      = 2'b00;
    bus.mem_address = 32'h0;
    bus.mem_byte_en = 4'h0;
    bus.mem_data_in = 32'h0;

    // Reset values; stalls mirror their requests while in reset.
    @(negedge clk);
    check("rst_we", {28'd0, bus.mmu_write_enable}, 32'd0);
    check("rst_mmu_addr", bus.mmu_address, 32'd0);
    check("rst_mmu_din", bus.mmu_data_in, 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_mem_data", bus.mem_data_out, 32'd0);
    check("rst_wait_if", {31'd0, bus.wait_if}, 32'd1);
    check("rst_wait_mem", {31'd0, bus.wait_mem}, 32'd0);
    bus.if_req = 1'b0;

    @(posedge clk);
    #1;
    mmu_init = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed: lone fetch, lone partial write, then simultaneous IF + MEM read.
    plan_if(cyc, 32'h0000_000A);
    if_port(32'h0000_000A);
    plan_mem(cyc, 2'b01, 32'h10, 4'b0011, 32'hDEAD_BEEF);
    mem_port(2'b01, 32'h10, 4'b0011, 32'hDEAD_BEEF);
    c0 = cyc;
    plan_mem(c0, 2'b10, 32'h10, 4'h0, 32'h0);
    plan_if(c0, 32'h20);
    fork
      if_port(32'h20);
      mem_port(2'b10, 32'h10, 4'h0, 32'h0);
    join
    // Two fetches of 0x20 around a write (buffer hit/miss behaviour).
    plan_if(cyc, 32'h20);
    if_port(32'h20);
    plan_mem(cyc, 2'b01, 32'h3C, 4'b1000, 32'h5500_0000);
    mem_port(2'b01, 32'h3C, 4'b1000, 32'h5500_0000);
    plan_if(cyc, 32'h20);
    if_port(32'h20);

    // Randomized traffic.
    for (int s = 0; s < 80; s++) begin
      kind = $urandom_range(0, 4);
      ia   = {26'd0, 4'($urandom_range(0, 7)), 2'b00};
      ma   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      md   = $urandom;
      be   = 4'($urandom_range(1, 15));
      mop  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      k    = $urandom_range(1, LAT);
      c0   = cyc;
      case (kind)
        0: begin
          plan_if(c0, ia);
          if_port(ia);
        end
        1, 2: begin
          plan_mem(c0, mop, ma, be, md);
          mem_port(mop, ma, be, md);
        end
        3: begin
          plan_mem(c0, mop, ma, be, md);
          plan_if(c0, ia);
          fork
            if_port(ia);
            mem_port(mop, ma, be, md);
          join
        end
        default: begin
          plan_if(c0, ia);
          plan_mem(c0 + k, mop, ma, be, md);
          fork
            if_port(ia);
            begin
              repeat (k) @(posedge clk);
              #1 mem_port(mop, ma, be, md);
            end
          join
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // op_mem 2'b11 behaves as no request.
    bus.op_mem = 2'b11;
    repeat (3) @(negedge clk);
    check("op11_wait_mem", {31'd0, bus.wait_mem}, 32'd0);
    check("op11_we", {28'd0, bus.mmu_write_enable}, 32'd0);
    @(posedge clk);
    #1 bus.op_mem = 2'b00;

    check("drain_if_q", if_q.size(), 32'd0);
    check("drain_mem_q", mem_q.size(), 32'd0);
    check("drain_wr_q", wr_q.size(), 32'd0);

    // Reset in the middle of a write cycle aborts it asynchronously.
    mon_en          = 1'b0;
    bus.mem_address = 32'h14;
    bus.mem_byte_en = 4'hF;
    bus.mem_data_in = 32'h1234_5678;
    bus.op_mem      = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("rstw_we_before", {28'd0, bus.mmu_write_enable}, 32'h0000_000F);
    reset = 1'b1;
    #1;
    check("rstw_we", {28'd0, bus.mmu_write_enable}, 32'd0);
    check("rstw_mmu_addr", bus.mmu_address, 32'd0);
    check("rstw_if_data", bus.if_data, 32'd0);
    check("rstw_mem_data", bus.mem_data_out, 32'd0);
    check("rstw_wait_mem", {31'd0, bus.wait_mem}, 32'd1);
    bus.op_mem = 2'b00;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    next_free = 0;
`ifdef MEMORY_CONTROL_IF_BUFFER_EN
    bufm_valid = 1'b0;
`endif
    mon_en = 1'b1;

    // The aborted write must not have reached the mmu; arbiter restarts idle.
    plan_if(cyc, 32'h14);
    if_port(32'h14);
    plan_mem(cyc, 2'b10, 32'h10, 4'h0, 32'h0);
    mem_port(2'b10, 32'h10, 4'h0, 32'h0);

    repeat (4) @(negedge clk);
    check("final_if_q", if_q.size(), 32'd0);
    check("final_mem_q", mem_q.size(), 32'd0);
    check("final_wr_q", wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
